public_test_seq_ctrl: RTL and testbench

Sequencing controller for the 8-bit public_test sequential garbling core (p/g/e accumulator registers plus an XOR output). It collects per-cycle words from three independent party channels (p, g, e) over valid/ready handshakes and loads the init words into the core. It then steps the core once per fully collected input triple, for a programmed number of circuit cycles, and returns each cycle's core output over a valid/ready result channel. It sits between the party input streams and the core. It is the only block that drives the core's reset/init pins and clock enable.

---
 rtl/public_test_seq_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_public_test_seq_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/public_test_seq_ctrl.sv
// Sequencing controller: collects p/g/e party words, loads and steps the public_test core, returns one result per step.
// Latency: start->first ready 1 cycle; last word->core_rst/core_en 1 cycle; best case 3 cycles per core step.
// Backpressure: each party ready drops once its slot fills; an unaccepted result stalls the run until res_ready.
// Optional: define PUBLIC_SEQ_TIMEOUT_EN to enable the LOAD/COLLECT idle watchdog and the sticky err flag.
module public_test_seq_ctrl #(
    parameter int W       = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    // run control
    input  logic             start,
    input  logic [CNT_W-1:0] num_cycles,
    // party channels
    input  logic             p_valid,
    input  logic [W-1:0]     p_data,
    output logic             p_ready,
    input  logic             g_valid,
    input  logic [W-1:0]     g_data,
    output logic             g_ready,
    input  logic             e_valid,
    input  logic [W-1:0]     e_data,
    output logic             e_ready,
    // core control and data
    output logic             core_rst,
    output logic             core_en,
    output logic [W-1:0]     p_init,
    output logic [W-1:0]     g_init,
    output logic [W-1:0]     e_init,
    output logic [W-1:0]     p_in,
    output logic [W-1:0]     g_in,
    output logic [W-1:0]     e_in,
    input  logic [W-1:0]     core_o,
    // result channel
    output logic             res_valid,
    output logic [W-1:0]     res_data,
    input  logic             res_ready,
    // status
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        INIT    = 3'd2,
        COLLECT = 3'd3,
        STEP    = 3'd4,
        EMIT    = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             p_full;
    logic             g_full;
    logic             e_full;

    logic             collecting;
    logic             p_acc;
    logic             g_acc;
    logic             e_acc;
    logic             all_full_next;
    logic             wd_fire;

    // A watchdog limit of zero would fire before any word could arrive.
    if (TIMEOUT < 1) begin : g_timeout_range
        $error("TIMEOUT must be at least 1");
    end

    // Readies come straight from registered state and slot flags, so they
    // are glitch-free and drop to 0 as soon as a slot fills or the phase ends.
    assign collecting    = (state == LOAD) || (state == COLLECT);
    assign p_ready       = collecting && !p_full;
    assign g_ready       = collecting && !g_full;
    assign e_ready       = collecting && !e_full;
    assign p_acc         = p_valid && p_ready;
    assign g_acc         = g_valid && g_ready;
    assign e_acc         = e_valid && e_ready;
    // True when the triple is complete including words accepted this cycle.
    assign all_full_next = (p_full || p_acc) && (g_full || g_acc) && (e_full || e_acc);
    assign busy          = (state != IDLE);

`ifdef PUBLIC_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd;
    logic            err_q;
    logic            any_acc;

    assign any_acc = p_acc || g_acc || e_acc;
    // Fires on the TIMEOUT-th consecutive collection cycle without a handshake.
    assign wd_fire = collecting && !any_acc && (wd == WD_W'(TIMEOUT - 1));
    assign err     = err_q;

    // Idle-cycle watchdog and sticky error; a new accepted start clears err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd    <= '0;
            err_q <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                err_q <= 1'b0;
            end else if (wd_fire) begin
                err_q <= 1'b1;
            end
            if (!collecting || any_acc || wd_fire) begin
                wd <= '0;
            end else begin
                wd <= wd + 1'b1;
            end
        end
    end
`else
    assign wd_fire = 1'b0;
    assign err     = 1'b0;
`endif

    // Main sequencing FSM; core_rst, core_en and done are single-cycle
    // registered pulses and are cleared by default every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            p_full    <= 1'b0;
            g_full    <= 1'b0;
            e_full    <= 1'b0;
            p_init    <= '0;
            g_init    <= '0;
            e_init    <= '0;
            p_in      <= '0;
            g_in      <= '0;
            e_in      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            core_rst  <= 1'b0;
            core_en   <= 1'b0;
            done      <= 1'b0;
        end else begin
            core_rst <= 1'b0;
            core_en  <= 1'b0;
            done     <= 1'b0;
            if (wd_fire) begin
                // Abandon the run: no done pulse, partially filled slots discarded.
                p_full <= 1'b0;
                g_full <= 1'b0;
                e_full <= 1'b0;
                state  <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (num_cycles != '0) begin
                                cnt   <= num_cycles;
                                state <= LOAD;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        if (p_acc) begin
                            p_init <= p_data;
                            p_full <= 1'b1;
                        end
                        if (g_acc) begin
                            g_init <= g_data;
                            g_full <= 1'b1;
                        end
                        if (e_acc) begin
                            e_init <= e_data;
                            e_full <= 1'b1;
                        end
                        if (all_full_next) begin
                            core_rst <= 1'b1;
                            state    <= INIT;
                        end
                    end
                    INIT: begin
                        // core_rst is high during this cycle; the core loads *_init.
                        p_full <= 1'b0;
                        g_full <= 1'b0;
                        e_full <= 1'b0;
                        state  <= COLLECT;
                    end
                    COLLECT: begin
                        if (p_acc) begin
                            p_in   <= p_data;
                            p_full <= 1'b1;
                        end
                        if (g_acc) begin
                            g_in   <= g_data;
                            g_full <= 1'b1;
                        end
                        if (e_acc) begin
                            e_in   <= e_data;
                            e_full <= 1'b1;
                        end
                        if (all_full_next) begin
                            core_en <= 1'b1;
                            state   <= STEP;
                        end
                    end
                    STEP: begin
                        // core_en is high now; core_o still reflects the pre-step
                        // register values and is captured on the same edge.
                        res_data  <= core_o;
                        res_valid <= 1'b1;
                        cnt       <= cnt - 1'b1;
                        p_full    <= 1'b0;
                        g_full    <= 1'b0;
                        e_full    <= 1'b0;
                        state     <= EMIT;
                    end
                    EMIT: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            if (cnt == '0) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                state <= COLLECT;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_public_test_seq_ctrl.sv
`timescale 1ns/1ps
// Bench for public_test_seq_ctrl: table vectors, hand-written corner sequences and randomized runs.
// Expected results come from a prefix-XOR model of the controller plus core (init words XOR all inputs so far).
// Inputs are driven 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_public_test_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] num_cycles = '0;
    logic       p_valid = 1'b0, g_valid = 1'b0, e_valid = 1'b0;
    logic [7:0] p_data = '0, g_data = '0, e_data = '0;
    logic       p_ready, g_ready, e_ready;
    logic       core_rst, core_en;
    logic [7:0] p_init, g_init, e_init, p_in, g_in, e_in;
    logic [7:0] core_o;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_ready = 1'b0;
    logic       busy, done, err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    public_test_seq_ctrl #(.W(8), .CNT_W(8), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .num_cycles(num_cycles),
        .p_valid(p_valid), .p_data(p_data), .p_ready(p_ready),
        .g_valid(g_valid), .g_data(g_data), .g_ready(g_ready),
        .e_valid(e_valid), .e_data(e_data), .e_ready(e_ready),
        .core_rst(core_rst), .core_en(core_en),
        .p_init(p_init), .g_init(g_init), .e_init(e_init),
        .p_in(p_in), .g_in(g_in), .e_in(e_in), .core_o(core_o),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy), .done(done), .err(err)
    );

    // Reference public_test core: three accumulator registers, XOR output.
    logic [7:0] cr_p, cr_g, cr_e;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cr_p <= '0; cr_g <= '0; cr_e <= '0;
        end else if (core_rst) begin
            cr_p <= p_init; cr_g <= g_init; cr_e <= e_init;
        end else if (core_en) begin
            cr_p <= cr_p ^ p_in; cr_g <= cr_g ^ g_in; cr_e <= cr_e ^ e_in;
        end
    end
    assign core_o = cr_p ^ cr_g ^ cr_e ^ p_in ^ g_in ^ e_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Pulse counters and per-run handshake counts.
    int rst_cnt = 0, en_cnt = 0, done_cnt = 0;
    int acc_p = 0, acc_g = 0, acc_e = 0, run_en = 0;
    int d0 = 0, r0 = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (p_valid && p_ready) acc_p++;
            if (g_valid && g_ready) acc_g++;
            if (e_valid && e_ready) acc_e++;
            if (core_rst || core_en)
                chk("rst_en_exclusive", 32'(core_rst && core_en), 32'd0);
            if (core_rst) begin
                rst_cnt++;
                chk("init_accepts", 32'({8'(acc_p), 8'(acc_g), 8'(acc_e)}), 32'h010101);
            end
            if (core_en) begin
                chk("step_accepts", 32'({8'(acc_p), 8'(acc_g), 8'(acc_e)}),
                    32'({3{8'(run_en + 2)}}));
                run_en++;
                en_cnt++;
            end
            if (done) done_cnt++;
        end
    end

    // Scoreboard: every held result must equal the front expected value.
    logic [7:0] exp_q[$];
    logic [7:0] popped;
    always @(negedge clk) begin
        if (rst && res_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL res_unexpected actual=%0h required=no_result", res_data);
            end else begin
                chk("res_data", 32'(res_data), 32'(exp_q[0]));
                if (res_ready) popped = exp_q.pop_front();
            end
        end
    end

    // Optional random result backpressure.
    bit rr_mode = 1'b0;
    initial forever begin
        @(posedge clk); #1;
        if (rr_mode) res_ready = ($urandom_range(0, 3) != 0);
    end

    logic [7:0] model_acc = '0;

    task automatic check_zero(input string nm);
        chk({nm, "_ctrl"}, 32'({busy, done, err, core_rst, core_en, p_ready, g_ready, e_ready, res_valid}), 32'd0);
        chk({nm, "_data"}, 32'({res_data, p_init, g_init, e_init}), 32'd0);
        chk({nm, "_in"}, 32'({p_in, g_in, e_in}), 32'd0);
    endtask

    task automatic start_run(input logic [7:0] n);
        start = 1'b1; num_cycles = n;
        acc_p = 0; acc_g = 0; acc_e = 0; run_en = 0;
        d0 = done_cnt; r0 = rst_cnt;
        @(posedge clk); #1;
        start = 1'b0; num_cycles = 8'h5A;
        @(negedge clk);
        chk("start_ready", 32'({busy, p_ready, g_ready, e_ready, err}), 32'b11110);
        @(posedge clk); #1;
    endtask

    // Offer one word per party, each after its own delay, until all three accepted.
    task automatic send3(input logic [7:0] pd, gd, ed, input int dp, dg, de);
        bit ap = 0, ag = 0, ae = 0;
        int t = 0;
        p_data = pd; g_data = gd; e_data = ed;
        while (!(ap && ag && ae) && t < 100) begin
            p_valid = !ap && (t >= dp);
            g_valid = !ag && (t >= dg);
            e_valid = !ae && (t >= de);
            @(negedge clk);
            if (p_valid && p_ready) ap = 1;
            if (g_valid && g_ready) ag = 1;
            if (e_valid && e_ready) ae = 1;
            @(posedge clk); #1;
            t++;
        end
        p_valid = 0; g_valid = 0; e_valid = 0;
        chk("send_accepts", 32'({ap, ag, ae}), 32'b111);
    endtask

    task automatic load_init(input logic [7:0] ip, ig, ie, input int dp, dg, de);
        model_acc = ip ^ ig ^ ie;
        send3(ip, ig, ie, dp, dg, de);
        @(negedge clk);
        chk("core_rst_latency", 32'({core_rst, core_en}), 32'b10);
        @(posedge clk); #1;
    endtask

    task automatic step(input logic [7:0] pd, gd, ed, input int dp, dg, de,
                        input bit use_exp, input logic [7:0] exp_v);
        model_acc = model_acc ^ pd ^ gd ^ ed;
        exp_q.push_back(use_exp ? exp_v : model_acc);
        send3(pd, gd, ed, dp, dg, de);
        @(negedge clk);
        chk("core_en_latency", 32'({core_en, core_rst}), 32'b10);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int n);
        for (int t = 0; t < 400; t++) begin
            if (done_cnt != d0) break;
            @(posedge clk); #1;
        end
        chk("done_count", 32'(done_cnt - d0), 32'd1);
        chk("step_count", 32'(run_en), 32'(n));
        chk("core_rst_count", 32'(rst_cnt - r0), 32'd1);
        chk("results_drained", 32'(exp_q.size()), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    task automatic run_random(input int n, input int maxd);
        start_run(8'(n));
        load_init(8'($urandom), 8'($urandom), 8'($urandom),
                  $urandom_range(0, maxd), $urandom_range(0, maxd), $urandom_range(0, maxd));
        for (int k = 0; k < n; k++)
            step(8'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(0, maxd), $urandom_range(0, maxd), $urandom_range(0, maxd), 1'b0, 8'h00);
        wait_done(n);
    endtask

    typedef struct {
        logic [7:0] ip, ig, ie, xp, xg, xe, res;
    } vec_t;
    vec_t tbl[4];

    initial begin
        logic [7:0] bp_exp;
        int e0;
        tbl[0] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h07};
        tbl[1] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        tbl[2] = '{8'h0F, 8'hF0, 8'h33, 8'h55, 8'hAA, 8'h01, 8'h32};
        tbl[3] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h2E};

        // Reset state
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic run: two steps, results 0x07 then 0x77
        res_ready = 1'b1;
        e0 = en_cnt;
        start_run(8'd2);
        load_init(8'h00, 8'h00, 8'h00, 0, 0, 0);
        step(8'h01, 8'h02, 8'h04, 0, 0, 0, 1'b1, 8'h07);
        step(8'h10, 8'h20, 8'h40, 0, 0, 0, 1'b1, 8'h77);
        wait_done(2);
        chk("basic_en_pulses", 32'(en_cnt - e0), 32'd2);

        // Table vectors: single-step runs with hand-computed results
        for (int i = 0; i < 4; i++) begin
            start_run(8'd1);
            load_init(tbl[i].ip, tbl[i].ig, tbl[i].ie, 0, 0, 0);
            step(tbl[i].xp, tbl[i].xg, tbl[i].xe, 0, 0, 0, 1'b1, tbl[i].res);
            wait_done(1);
        end

        // Staggered arrival (e late by 5), then simultaneous
        start_run(8'd2);
        load_init(8'h3C, 8'hC3, 8'h81, 0, 0, 5);
        step(8'h11, 8'h22, 8'h44, 0, 0, 5, 1'b0, 8'h00);
        step(8'h08, 8'h80, 8'hF0, 2, 2, 2, 1'b0, 8'h00);
        wait_done(2);

        // Result backpressure: result held 10 cycles while next words wait
        res_ready = 1'b0;
        start_run(8'd2);
        load_init(8'hA0, 8'h0B, 8'h00, 0, 0, 0);
        step(8'h01, 8'h10, 8'h00, 0, 0, 0, 1'b0, 8'h00);
        bp_exp = model_acc;
        p_valid = 1; g_valid = 1; e_valid = 1;
        p_data = 8'h55; g_data = 8'h66; e_data = 8'h77;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_hold", 32'({res_valid, res_data}), 32'({1'b1, bp_exp}));
            chk("bp_no_ready", 32'({p_ready, g_ready, e_ready, core_en}), 32'd0);
            @(posedge clk); #1;
        end
        p_valid = 0; g_valid = 0; e_valid = 0;
        res_ready = 1'b1;
        step(8'h55, 8'h66, 8'h77, 0, 0, 0, 1'b0, 8'h00);
        wait_done(2);

        // Zero cycles: done pulse only
        d0 = done_cnt; r0 = rst_cnt; e0 = en_cnt;
        start = 1'b1; num_cycles = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_done", 32'({done, busy}), 32'b10);
        @(posedge clk); #1;
        @(negedge clk);
        chk("zero_done_width", 32'(done), 32'd0);
        @(posedge clk); #1;
        chk("zero_no_core_ops", 32'((rst_cnt - r0) + (en_cnt - e0)), 32'd0);
        chk("zero_done_count", 32'(done_cnt - d0), 32'd1);

        // Start while busy is ignored
        start_run(8'd2);
        load_init(8'h01, 8'h02, 8'h03, 0, 0, 0);
        start = 1'b1; num_cycles = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_start_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        step(8'h0A, 8'h0B, 8'h0C, 0, 1, 0, 1'b0, 8'h00);
        step(8'hD0, 8'hE0, 8'hF0, 1, 0, 0, 1'b0, 8'h00);
        wait_done(2);

        // Asynchronous reset mid-COLLECT
        start_run(8'd1);
        load_init(8'h5A, 8'hA5, 8'h0F, 0, 0, 0);
        p_valid = 1; p_data = 8'hAA;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_zero("midrst");
        p_valid = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        run_random(2, 0);

        // Randomized runs with random delays and random result backpressure
        rr_mode = 1'b1;
        for (int r = 0; r < 8; r++) run_random($urandom_range(1, 4), 4);
        rr_mode = 1'b0;
        @(posedge clk); #1;
        res_ready = 1'b1;

`ifdef PUBLIC_SEQ_TIMEOUT_EN
        // Watchdog: g never offered in COLLECT
        start_run(8'd1);
        load_init(8'h01, 8'h01, 8'h01, 0, 0, 0);
        p_valid = 1; e_valid = 1; p_data = 8'h10; e_data = 8'h20;
        @(negedge clk);
        chk("wd_pe_accept", 32'({p_ready, e_ready}), 32'b11);
        @(posedge clk); #1;
        p_valid = 0; e_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("wd_no_early_err", 32'({err, busy}), 32'b01);
        end
        @(negedge clk);
        chk("wd_err_idle", 32'({err, busy, g_ready}), 32'b100);
        chk("wd_no_done", 32'(done_cnt - d0), 32'd0);
        @(posedge clk); #1;
        run_random(1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit");
    end

endmodule
